// File: rtl/dpwm_deadtime_gen.sv
// Sawtooth DPWM with complementary dead-time gate outputs and shadow-buffered configuration.
// Define SOFT_START_EN to build the per-period duty ramp (ss_done tied high otherwise).
module dpwm_deadtime_gen #(
   parameter int CNT_W = 10,
   parameter int DT_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] duty,
   input  logic [DT_W-1:0]  dt_rise,
   input  logic [DT_W-1:0]  dt_fall,
   input  logic             load,
   output logic             load_ack,
   output logic [CNT_W-1:0] cnt,
   output logic             period_start,
   output logic             gate_hi,
   output logic             gate_lo,
   output logic             ss_done
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [DT_W-1:0]  DT_ONE  = DT_W'(1);
`ifdef SOFT_START_EN
   localparam logic SS_DONE_RST = 1'b0;
`else
   localparam logic SS_DONE_RST = 1'b1;
`endif

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [CNT_W-1:0] period_stg_r;
   logic [CNT_W-1:0] duty_stg_r;
   logic [DT_W-1:0]  dtr_stg_r;
   logic [DT_W-1:0]  dtf_stg_r;
   logic [CNT_W-1:0] period_sh_r;
   logic [CNT_W-1:0] duty_sh_r;
   logic [DT_W-1:0]  dtr_sh_r;
   logic [DT_W-1:0]  dtf_sh_r;
   logic             pend_r;
   logic             load_ack_r;
   logic             period_start_r;
   logic             gate_hi_r;
   logic             gate_lo_r;
   logic             pwm_prev_r;
   logic             ss_done_r;
   logic [DT_W-1:0]  dt_cnt_r;
   logic [DT_W-1:0]  dt_cnt_s;
   logic             gate_hi_s;
   logic             gate_lo_s;
   logic             wrap_s;
   logic             xfer_s;
   logic             pwm_raw_s;
   logic [CNT_W-1:0] d_used_s;
   logic [CNT_W-1:0] duty_nxt_s;
   logic             ss_done_s;

   // Counter wrap detection and shadow transfer decision
   always_comb begin
      wrap_s = en && (cnt_r == period_sh_r);
      xfer_s = pend_r && (wrap_s || !en);
      if (!en) begin
         cnt_s = '0;
      end else if (wrap_s) begin
         cnt_s = '0;
      end else begin
         cnt_s = cnt_r + CNT_ONE;
      end
      if (xfer_s) begin
         duty_nxt_s = duty_stg_r;
      end else begin
         duty_nxt_s = duty_sh_r;
      end
   end

`ifdef SOFT_START_EN
   logic [CNT_W-1:0] d_ss_r;
   logic [CNT_W-1:0] d_ss_s;

   // Ramp climbs one count per wrap; a duty decrease pulls it down at once
   always_comb begin
      if (!en) begin
         d_ss_s = '0;
      end else if (d_ss_r > duty_sh_r) begin
         d_ss_s = duty_sh_r;
      end else if (wrap_s && (d_ss_r < duty_sh_r)) begin
         d_ss_s = d_ss_r + CNT_ONE;
      end else begin
         d_ss_s = d_ss_r;
      end
      if (d_ss_r < duty_sh_r) begin
         d_used_s = d_ss_r;
      end else begin
         d_used_s = duty_sh_r;
      end
      ss_done_s = (d_ss_s >= duty_nxt_s);
   end

   // Ramp register
   always_ff @(posedge clk) begin
      if (reset) begin
         d_ss_r <= '0;
      end else begin
         d_ss_r <= d_ss_s;
      end
   end
`else
   // Without the ramp the commanded duty is used directly
   always_comb begin
      d_used_s  = duty_sh_r;
      ss_done_s = 1'b1;
   end
`endif

   // Edge-armed dead-time counter and gate next-state; gates are complementary or both off
   always_comb begin
      pwm_raw_s = (cnt_r < d_used_s);
      gate_hi_s = 1'b0;
      gate_lo_s = 1'b0;
      dt_cnt_s  = dt_cnt_r;
      if (!en) begin
         dt_cnt_s = '0;
      end else if (pwm_raw_s != pwm_prev_r) begin
         if (pwm_raw_s) begin
            if (dtr_sh_r == '0) begin
               gate_hi_s = 1'b1;
               dt_cnt_s  = '0;
            end else begin
               dt_cnt_s  = dtr_sh_r;
            end
         end else begin
            if (dtf_sh_r == '0) begin
               gate_lo_s = 1'b1;
               dt_cnt_s  = '0;
            end else begin
               dt_cnt_s  = dtf_sh_r;
            end
         end
      end else if (dt_cnt_r != '0) begin
         dt_cnt_s = dt_cnt_r - DT_ONE;
         if (dt_cnt_r == DT_ONE) begin
            gate_hi_s = pwm_raw_s;
            gate_lo_s = !pwm_raw_s;
         end else begin
            gate_hi_s = 1'b0;
            gate_lo_s = 1'b0;
         end
      end else begin
         gate_hi_s = pwm_raw_s;
         gate_lo_s = !pwm_raw_s;
      end
   end

   // Counter, staging/shadow configuration and handshake registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r          <= '0;
         period_start_r <= 1'b0;
         load_ack_r     <= 1'b0;
         pend_r         <= 1'b0;
         period_stg_r   <= '0;
         duty_stg_r     <= '0;
         dtr_stg_r      <= '0;
         dtf_stg_r      <= '0;
         period_sh_r    <= '0;
         duty_sh_r      <= '0;
         dtr_sh_r       <= '0;
         dtf_sh_r       <= '0;
      end else begin
         cnt_r          <= cnt_s;
         period_start_r <= en && (cnt_s == '0);
         load_ack_r     <= xfer_s;
         pend_r         <= load || (pend_r && !xfer_s);
         if (load) begin
            period_stg_r <= period;
            duty_stg_r   <= duty;
            dtr_stg_r    <= dt_rise;
            dtf_stg_r    <= dt_fall;
         end
         if (xfer_s) begin
            period_sh_r  <= period_stg_r;
            duty_sh_r    <= duty_stg_r;
            dtr_sh_r     <= dtr_stg_r;
            dtf_sh_r     <= dtf_stg_r;
         end
      end
   end

   // Gate, dead-time and status registers; low side is masked by high side as a last guard
   always_ff @(posedge clk) begin
      if (reset) begin
         gate_hi_r  <= 1'b0;
         gate_lo_r  <= 1'b0;
         pwm_prev_r <= 1'b0;
         dt_cnt_r   <= '0;
         ss_done_r  <= SS_DONE_RST;
      end else begin
         gate_hi_r  <= gate_hi_s;
         gate_lo_r  <= gate_lo_s && !gate_hi_s;
         pwm_prev_r <= en && pwm_raw_s;
         dt_cnt_r   <= dt_cnt_s;
         ss_done_r  <= ss_done_s;
      end
   end

   assign cnt          = cnt_r;
   assign period_start = period_start_r;
   assign load_ack     = load_ack_r;
   assign gate_hi      = gate_hi_r;
   assign gate_lo      = gate_lo_r;
   assign ss_done      = ss_done_r;

endmodule

// File: tb/tb_dpwm_deadtime_gen.sv
// Directed self-checking bench for dpwm_deadtime_gen (CNT_W=10, DT_W=4).
// Soft-start ramp vectors run when SOFT_START_EN is defined; otherwise the plain PWM vectors run.
module tb_dpwm_deadtime_gen;

   logic       clk;
   logic       reset;
   logic       en;
   logic       load;
   logic [9:0] period;
   logic [9:0] duty;
   logic [3:0] dt_rise;
   logic [3:0] dt_fall;
   logic       load_ack;
   logic [9:0] cnt;
   logic       period_start;
   logic       gate_hi;
   logic       gate_lo;
   logic       ss_done;

   int n_cmp = 0;
   int n_err = 0;
   int overlap_cnt = 0;
   int hi;
   int lo;
   int ack;
   int n;

`ifdef SOFT_START_EN
   localparam int SS_RST = 0;
`else
   localparam int SS_RST = 1;
`endif

   dpwm_deadtime_gen #(.CNT_W(10), .DT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .period       (period),
      .duty         (duty),
      .dt_rise      (dt_rise),
      .dt_fall      (dt_fall),
      .load         (load),
      .load_ack     (load_ack),
      .cnt          (cnt),
      .period_start (period_start),
      .gate_hi      (gate_hi),
      .gate_lo      (gate_lo),
      .ss_done      (ss_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (gate_hi && gate_lo) overlap_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t reached, required finish before 100000", $time);
      $fatal(1);
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_cfg(input int p, input int d, input int r, input int f);
      period  = 10'(p);
      duty    = 10'(d);
      dt_rise = 4'(r);
      dt_fall = 4'(f);
      load    = 1'b1;
      @(negedge clk);
      load    = 1'b0;
   endtask

   task automatic sync_cnt(input int target);
      int k;
      k = 0;
      while ((32'(cnt) != target) && (k < 64)) begin
         @(negedge clk);
         k++;
      end
      check("sync_cnt", 32'(cnt), target);
   endtask

   task automatic sync_start();
      sync_cnt(9);
      @(negedge clk);
   endtask

   task automatic measure(output int h, output int l, output int a);
      h = 0;
      l = 0;
      a = 0;
      for (int i = 0; i < 10; i++) begin
         h += 32'(gate_hi);
         l += 32'(gate_lo);
         a += 32'(load_ack);
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; load = 1'b0;
      period = 10'd0; duty = 10'd0; dt_rise = 4'd0; dt_fall = 4'd0;
      repeat (2) @(negedge clk);
      check("rst_cnt", 32'(cnt), 0);
      check("rst_gate_hi", 32'(gate_hi), 0);
      check("rst_gate_lo", 32'(gate_lo), 0);
      check("rst_period_start", 32'(period_start), 0);
      check("rst_load_ack", 32'(load_ack), 0);
      check("rst_ss_done", 32'(ss_done), SS_RST);
      reset = 1'b0;

`ifdef SOFT_START_EN
      load_cfg(9, 5, 0, 0);
      @(negedge clk);
      check("ss_cfg_ack", 32'(load_ack), 1);
      check("ss_done_start", 32'(ss_done), 0);
      en = 1'b1;
      hi = 0;
      n = 0;
      @(negedge clk);
      while ((cnt != 10'd0) && (n < 20)) begin
         hi += 32'(gate_hi);
         @(negedge clk);
         n++;
      end
      check("ss_sync", 32'(cnt), 0);
      check("ss_width_p0", hi, 0);
      for (int k = 1; k <= 7; k++) begin
         check("ss_done_at_wrap", 32'(ss_done), (k >= 5) ? 1 : 0);
         measure(hi, lo, ack);
         check("ss_width", hi, (k < 5) ? k : 5);
      end
`else
      // steady PWM: period 9, duty 4, dt_rise 2, dt_fall 1
      load_cfg(9, 4, 2, 1);
      check("cfg_ack_pre", 32'(load_ack), 0);
      @(negedge clk);
      check("cfg_ack", 32'(load_ack), 1);
      @(negedge clk);
      check("cfg_ack_clr", 32'(load_ack), 0);
      en = 1'b1;
      @(negedge clk);
      check("en_cnt_first", 32'(cnt), 1);
      sync_start();
      check("steady_period_start", 32'(period_start), 1);
      for (int k = 0; k < 2; k++) begin
         measure(hi, lo, ack);
         check("steady_hi", hi, 2);
         check("steady_lo", lo, 5);
      end

      // mid-period reload duty 4 -> 7 at cnt 5
      sync_cnt(5);
      load_cfg(9, 7, 2, 1);
      hi = 0; lo = 0; ack = 0;
      for (int i = 0; i < 4; i++) begin
         hi += 32'(gate_hi);
         lo += 32'(gate_lo);
         ack += 32'(load_ack);
         @(negedge clk);
      end
      check("reload_cur_hi", hi, 0);
      check("reload_cur_lo", lo, 4);
      check("reload_cur_ack", ack, 0);
      check("reload_wrap_cnt", 32'(cnt), 0);
      measure(hi, lo, ack);
      check("reload_new_hi", hi, 5);
      check("reload_new_lo", lo, 2);
      check("reload_ack_once", ack, 1);
      measure(hi, lo, ack);
      check("reload_next_hi", hi, 5);
      check("reload_next_ack", ack, 0);

      // full duty: duty 12 > period 9
      sync_cnt(2);
      load_cfg(9, 12, 2, 1);
      sync_start();
      measure(hi, lo, ack);
      for (int k = 0; k < 2; k++) begin
         measure(hi, lo, ack);
         check("full_hi", hi, 10);
         check("full_lo", lo, 0);
      end

      // short pulse swallowed by dead time
      sync_cnt(2);
      load_cfg(9, 1, 3, 2);
      sync_start();
      measure(hi, lo, ack);
      for (int k = 0; k < 2; k++) begin
         measure(hi, lo, ack);
         check("short_hi", hi, 0);
         check("short_lo", lo, 7);
      end

      // en dropped at cnt 3 while gate_hi is on
      sync_cnt(2);
      load_cfg(9, 4, 2, 1);
      sync_start();
      measure(hi, lo, ack);
      sync_cnt(3);
      check("endrop_pre_hi", 32'(gate_hi), 1);
      en = 1'b0;
      @(negedge clk);
      check("endrop_hi", 32'(gate_hi), 0);
      check("endrop_lo", 32'(gate_lo), 0);
      check("endrop_cnt", 32'(cnt), 0);
      repeat (2) @(negedge clk);
      check("endrop_hold_cnt", 32'(cnt), 0);
      check("endrop_period_start", 32'(period_start), 0);
      en = 1'b1;
      @(negedge clk);
      check("enrise_cnt", 32'(cnt), 1);
      sync_start();
      measure(hi, lo, ack);
      check("enrise_hi", hi, 2);
      check("enrise_lo", lo, 5);
      check("ss_done_tied", 32'(ss_done), 1);
`endif

      // reset mid-run, then reset coincident with load
      sync_cnt(3);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_cnt", 32'(cnt), 0);
      check("midrst_hi", 32'(gate_hi), 0);
      check("midrst_lo", 32'(gate_lo), 0);
      check("midrst_period_start", 32'(period_start), 0);
      check("midrst_load_ack", 32'(load_ack), 0);
      check("midrst_ss_done", 32'(ss_done), SS_RST);
      en = 1'b0;
      load_cfg(9, 4, 2, 1);
      reset = 1'b0;
      ack = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ack += 32'(load_ack);
      end
      check("rst_beats_load", ack, 0);
      en = 1'b1;
      repeat (3) @(negedge clk);
      check("cleared_shadow_cnt", 32'(cnt), 0);
      check("cleared_shadow_hi", 32'(gate_hi), 0);
      check("cleared_shadow_lo", 32'(gate_lo), 1);
      check("cleared_shadow_ps", 32'(period_start), 1);

      check("no_overlap", overlap_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
